// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 SCCB write master.
package ov7670_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StBits,
    StStop,
    StGap,
    StDelay,
    StDone,
    StHold
  } sccb_state_e;

  localparam logic [15:0] SCCB_END_MARKER = 16'hFFFF;
  localparam logic [7:0]  REG_COM7        = 8'h12;
  localparam int unsigned COM7_RESET_BIT  = 7;
  localparam logic [4:0]  LAST_SLOT       = 5'd26;

  // Don't-care slots follow each byte; the bus is released for the whole slot.
  localparam logic [26:0] SCCB_OE_MASK = {8'hFF, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0};

  typedef struct packed {
    logic sioc;
    logic siod;
    logic oe;
  } sccb_bus_t;

  // Pad levels for a given state/quarter; anything outside a frame idles the line high.
  function automatic sccb_bus_t bus_drive(sccb_state_e st, logic [1:0] q, logic bit_val,
                                          logic bit_oe);
    sccb_bus_t b;
    b.sioc = 1'b1;
    b.siod = 1'b1;
    b.oe   = 1'b1;
    case (st)
      StStart: begin
        b.sioc = (q < 2'd2);
        b.siod = (q == 2'd0);
      end
      StBits: begin
        b.sioc = (q == 2'd1) || (q == 2'd2);
        b.siod = bit_val;
        b.oe   = bit_oe;
      end
      StStop: begin
        b.sioc = (q != 2'd0);
        b.siod = (q == 2'd3);
      end
      default: ;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sccb_qtr_tick.sv
// Free-running quarter-period tick; `sync` restarts the count so a frame starts on a
// full quarter.
module sccb_qtr_tick #(
  parameter int unsigned QTR = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic sync,
  output logic qt
);

  localparam int unsigned CntW = $clog2(QTR + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(QTR - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || sync) begin
      cnt_q <= '0;
    end else if (cnt_q == LastCnt) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign qt = (cnt_q == LastCnt);

endmodule

// File: rtl/ov7670_sccb_master.sv
// SCCB 3-phase write master: START, device ID, register address, value, STOP, with an
// optional settle delay after a COM7 soft reset.
module ov7670_sccb_master
  import ov7670_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ        = 25_000_000,
  parameter int unsigned SCCB_FREQ_HZ       = 100_000,
  parameter logic [7:0]  DEV_ADDR           = 8'h42,
  parameter int unsigned RESET_DELAY_CYCLES = 25_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        sioc,
  output logic        siod_out,
  output logic        siod_oe
);

  localparam int unsigned QTR      = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
  localparam bit          HasDelay = (RESET_DELAY_CYCLES != 0);
  localparam int unsigned DlyW     = (RESET_DELAY_CYCLES > 1) ? $clog2(RESET_DELAY_CYCLES) : 1;
  localparam logic [DlyW-1:0] DlyLoad = DlyW'(RESET_DELAY_CYCLES - 1);

  if (QTR < 1) begin : g_qtr_check
    $error("ov7670_sccb_master: CLK_FREQ_HZ/(4*SCCB_FREQ_HZ) must be at least 1");
  end

  sccb_state_e     state_q, state_d;
  logic [1:0]      qidx_q, qidx_d;
  logic [4:0]      slot_q, slot_d;
  logic [26:0]     frame_q, frame_d;
  logic [26:0]     mask_q, mask_d;
  logic [DlyW-1:0] dly_q, dly_d;
  logic            com7_q, com7_d;
  logic            sync;
  logic            qt;
  sccb_bus_t       bus_d;
  logic            busy_d;
  logic            done_d;

  sccb_qtr_tick #(
    .QTR(QTR)
  ) u_qtr_tick (
    .clk  (clk),
    .reset(reset),
    .sync (sync),
    .qt   (qt)
  );

  always_comb begin
    state_d = state_q;
    qidx_d  = qidx_q;
    slot_d  = slot_q;
    frame_d = frame_q;
    mask_d  = mask_q;
    dly_d   = dly_q;
    com7_d  = com7_q;
    sync    = 1'b0;

    case (state_q)
      StIdle: begin
        if (start && (data != SCCB_END_MARKER)) begin
          state_d = StStart;
          qidx_d  = 2'd0;
          slot_d  = 5'd0;
          frame_d = {DEV_ADDR, 1'b1, data[15:8], 1'b1, data[7:0], 1'b1};
          mask_d  = SCCB_OE_MASK;
          com7_d  = (data[15:8] == REG_COM7) && data[COM7_RESET_BIT];
          sync    = 1'b1;
        end
      end
      StStart: begin
        if (qt) begin
          qidx_d = qidx_q + 2'd1;
          if (qidx_q == 2'd3) begin
            state_d = StBits;
          end
        end
      end
      StBits: begin
        if (qt) begin
          qidx_d = qidx_q + 2'd1;
          if (qidx_q == 2'd3) begin
            frame_d = {frame_q[25:0], 1'b1};
            mask_d  = {mask_q[25:0], 1'b0};
            if (slot_q == LAST_SLOT) begin
              state_d = StStop;
            end else begin
              slot_d = slot_q + 5'd1;
            end
          end
        end
      end
      StStop: begin
        if (qt) begin
          qidx_d = qidx_q + 2'd1;
          if (qidx_q == 2'd3) begin
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (qt) begin
          qidx_d = qidx_q + 2'd1;
          if (qidx_q == 2'd3) begin
            if (com7_q && HasDelay) begin
              state_d = StDelay;
              dly_d   = DlyLoad;
            end else begin
              state_d = StDone;
            end
          end
        end
      end
      StDelay: begin
        if (dly_q == '0) begin
          state_d = StDone;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      StDone:  state_d = StHold;
      StHold:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state register
  // while still letting reset force the released-bus values.
  assign bus_d  = bus_drive(state_d, qidx_d, frame_d[26], mask_d[26]);
  assign busy_d = !(state_d inside {StIdle, StHold});
  assign done_d = (state_d == StDone);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      qidx_q   <= 2'd0;
      slot_q   <= 5'd0;
      frame_q  <= '1;
      mask_q   <= '0;
      dly_q    <= '0;
      com7_q   <= 1'b0;
      sioc     <= 1'b1;
      siod_out <= 1'b1;
      siod_oe  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      qidx_q   <= qidx_d;
      slot_q   <= slot_d;
      frame_q  <= frame_d;
      mask_q   <= mask_d;
      dly_q    <= dly_d;
      com7_q   <= com7_d;
      sioc     <= bus_d.sioc;
      siod_out <= bus_d.siod;
      siod_oe  <= bus_d.oe;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_ov7670_sccb_master.sv
// Bench for ov7670_sccb_master: waveform-table model, per-cycle compare, SIOC-rise decoder
// and bus protocol checks, plus directed literal expectations.
module tb_ov7670_sccb_master;

  localparam int unsigned CLK_HZ  = 400;
  localparam int unsigned SCCB_HZ = 100;
  localparam int unsigned DLY     = 50;
  localparam int unsigned QTR     = CLK_HZ / (4 * SCCB_HZ);
  localparam logic [7:0]  DEV     = 8'h42;

  localparam int TagIdle  = 0;
  localparam int TagStart = 1;
  localparam int TagBit   = 2;
  localparam int TagX     = 3;
  localparam int TagStop  = 4;
  localparam int TagReset = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] data = 16'h0000;
  logic        busy, done, sioc, siod_out, siod_oe;

  always #5 clk = ~clk;

  ov7670_sccb_master #(
    .CLK_FREQ_HZ       (CLK_HZ),
    .SCCB_FREQ_HZ      (SCCB_HZ),
    .DEV_ADDR          (DEV),
    .RESET_DELAY_CYCLES(DLY)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .data    (data),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .sioc    (sioc),
    .siod_out(siod_out),
    .siod_oe (siod_oe)
  );

  typedef struct {
    logic sioc;
    logic oe;
    logic out;
    logic chk_out;
    logic busy;
    logic done;
    int   tag;
  } exp_t;

  exp_t mq[$];
  exp_t cur;
  bit   have_cur = 0;
  bit   ready = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  function automatic exp_t mk(input logic sc, input logic oe, input logic out, input logic bsy,
                              input logic dn, input int tag);
    exp_t e;
    e.sioc = sc;
    e.oe = oe;
    e.out = out;
    e.chk_out = oe;
    e.busy = bsy;
    e.done = dn;
    e.tag = tag;
    return e;
  endfunction

  // One slot = four quarters; patterns list q0..q3 from MSB to LSB.
  function automatic void push_quarters(input logic [3:0] sc, input logic [3:0] sd,
                                        input logic oe, input int tag);
    for (int q = 0; q < 4; q++) begin
      for (int r = 0; r < int'(QTR); r++) begin
        mq.push_back(mk(sc[3-q], oe, sd[3-q], 1'b1, 1'b0, tag));
      end
    end
  endfunction

  function automatic void push_frame(input logic [15:0] w);
    logic [7:0] by[3];
    by[0] = DEV;
    by[1] = w[15:8];
    by[2] = w[7:0];
    push_quarters(4'b1100, 4'b1000, 1'b1, TagStart);
    for (int i = 0; i < 3; i++) begin
      for (int j = 7; j >= 0; j--) begin
        push_quarters(4'b0110, {4{by[i][j]}}, 1'b1, TagBit);
      end
      push_quarters(4'b0110, 4'b1111, 1'b0, TagX);
    end
    push_quarters(4'b0111, 4'b0001, 1'b1, TagStop);
    push_quarters(4'b1111, 4'b1111, 1'b1, TagIdle);
    if (w[15:8] == 8'h12 && w[7]) begin
      for (int k = 0; k < int'(DLY); k++) mq.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, TagIdle));
    end
    mq.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, TagIdle));
    mq.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, TagIdle));
  endfunction

  // Model: decides what every cycle must look like, starting a frame only after an idle cycle.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      mq.delete();
      cur = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, TagReset);
      cur.chk_out = 1'b1;
      ready = 1;
    end else if (mq.size() > 0) begin
      cur = mq.pop_front();
      ready = 0;
    end else if (ready && start && data != 16'hFFFF) begin
      push_frame(data);
      cur = mq.pop_front();
      ready = 0;
    end else begin
      cur = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, TagIdle);
      ready = 1;
    end
    have_cur = 1;
  end

  logic       pad, prev_sioc, prev_pad;
  bit         prev_valid = 0;
  int         rises = 0;
  int         last_rise = -1;
  logic       bits[27];
  logic       xs[27];
  logic [7:0] dec_dev, dec_addr, dec_val;
  int         dec_xok, dec_n;

  always @(negedge clk) begin
    if (have_cur) begin
      pad = siod_oe ? siod_out : 1'b1;
      n_cmp++;
      if (sioc !== cur.sioc || siod_oe !== cur.oe || busy !== cur.busy || done !== cur.done ||
          (cur.chk_out && siod_out !== cur.out)) begin
        n_fail++;
        $display("FAIL cycle_%0d tag %0d: sioc/oe/out/busy/done got %b%b%b%b%b expected %b%b%b%b%b",
                 cyc, cur.tag, sioc, siod_oe, siod_out, busy, done,
                 cur.sioc, cur.oe, cur.out, cur.busy, cur.done);
      end
      if (prev_valid && cur.tag != TagReset && sioc && prev_sioc && pad !== prev_pad) begin
        n_cmp++;
        if (cur.tag != TagStart && cur.tag != TagStop) begin
          n_fail++;
          $display("FAIL siod_edge_sioc_high cycle %0d: got edge %b->%b, required none",
                   cyc, prev_pad, pad);
        end
      end
      if (cur.tag == TagReset) begin
        rises = 0;
        last_rise = -1;
      end else if (sioc && !prev_sioc && busy) begin
        if (last_rise >= 0) begin
          n_cmp++;
          if (cyc - last_rise != 4 * int'(QTR)) begin
            n_fail++;
            $display("FAIL sioc_period cycle %0d: got %0d, required %0d",
                     cyc, cyc - last_rise, 4 * QTR);
          end
        end
        last_rise = cyc;
        if (rises < 27) begin
          bits[rises] = pad;
          xs[rises] = !siod_oe;
        end
        rises++;
      end
      if (done === 1'b1) begin
        dec_xok = 1;
        for (int i = 0; i < 27; i++) begin
          if (xs[i] != (i == 8 || i == 17 || i == 26)) dec_xok = 0;
        end
        for (int i = 0; i < 8; i++) begin
          dec_dev[7-i]  = bits[i];
          dec_addr[7-i] = bits[9+i];
          dec_val[7-i]  = bits[18+i];
        end
        dec_n = rises;
        rises = 0;
        last_rise = -1;
      end
      prev_sioc = sioc;
      prev_pad = pad;
      prev_valid = 1;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input string name, output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 1000) begin
      step();
      lat++;
    end
    if (done !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no done after %0d cycles, required a done pulse", name, lat);
    end
  endtask

  task automatic check_frame(input string name, input logic [7:0] a, input logic [7:0] v);
    check({name, "_dev"}, int'(dec_dev), int'(DEV));
    check({name, "_addr"}, int'(dec_addr), int'(a));
    check({name, "_val"}, int'(dec_val), int'(v));
    check({name, "_xslots"}, dec_xok, 1);
    check({name, "_rises"}, dec_n, 28);
  endtask

  task automatic send(input logic [15:0] w, input string name, output int lat);
    data = w;
    start = 1'b1;
    step();
    start = 1'b0;
    check({name, "_busy_on_accept"}, int'(busy), 1);
    wait_done(name, lat);
    step();
    step();
  endtask

  int lat;
  int bad;

  initial begin
    step();
    step();
    check("reset_outputs", int'({sioc, siod_oe, siod_out, busy, done}), 'b10100);
    reset = 1'b0;
    step();
    check("idle_after_reset", int'({sioc, siod_oe, siod_out, busy, done}), 'b11100);

    send(16'h1204, "t1", lat);
    check("t1_latency", lat, 120);
    check_frame("t1", 8'h12, 8'h04);

    send(16'h1280, "t2_com7", lat);
    check("t2_com7_latency", lat, 170);
    check_frame("t2_com7", 8'h12, 8'h80);
    send(16'h1200, "t2_plain", lat);
    check("t2_plain_latency", lat, 120);

    data = 16'hFFFF;
    start = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (sioc !== 1'b1 || siod_oe !== 1'b1 || siod_out !== 1'b1 || busy !== 1'b0 ||
          done !== 1'b0) bad++;
    end
    check("t3_end_marker_ignored", bad, 0);
    start = 1'b0;
    step();

    data = 16'h1111;
    start = 1'b1;
    step();
    check("t4_busy_first", int'(busy), 1);
    repeat (60) step();
    data = 16'hDEAD;
    wait_done("t4_first", lat);
    check("t4_first_latency_rest", lat, 60);
    check_frame("t4_first", 8'h11, 8'h11);
    step();
    check("t4_hold_not_busy", int'(busy), 0);
    step();
    check("t4_idle_not_busy", int'(busy), 0);
    data = 16'h2233;
    step();
    check("t4_second_start_after_hold", int'(busy), 1);
    start = 1'b0;
    wait_done("t4_second", lat);
    check("t4_second_latency", lat, 120);
    check_frame("t4_second", 8'h22, 8'h33);
    step();
    step();

    data = 16'h5678;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (46) step();
    check("t5_slot10_q2_sioc", int'(sioc), 1);
    reset = 1'b1;
    step();
    check("t5_reset_release", int'({sioc, siod_oe, busy, done}), 'b1000);
    reset = 1'b0;
    step();
    check("t5_idle_after_reset", int'({sioc, siod_oe, siod_out, busy}), 'b1110);
    send(16'h3a04, "t5", lat);
    check("t5_latency", lat, 120);
    check_frame("t5", 8'h3a, 8'h04);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, required completion within 1 ms");
    $fatal(1, "bench watchdog expired");
  end

endmodule
